// File: rtl/diffeq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : diffeq_pkg
// Brief    : Shared FSM encoding and width helper for the diffeq_solver block.
// Revision : 1.0
// ============================================================================
package diffeq_pkg;

    localparam logic [5:0] c_ST_IDLE  = 6'b000001;
    localparam logic [5:0] c_ST_CHECK = 6'b000010;
    localparam logic [5:0] c_ST_CALC1 = 6'b000100;
    localparam logic [5:0] c_ST_CALC2 = 6'b001000;
    localparam logic [5:0] c_ST_CALC3 = 6'b010000;
    localparam logic [5:0] c_ST_DONE  = 6'b100000;

    typedef enum logic [5:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_CHECK = c_ST_CHECK,
        ST_CALC1 = c_ST_CALC1,
        ST_CALC2 = c_ST_CALC2,
        ST_CALC3 = c_ST_CALC3,
        ST_DONE  = c_ST_DONE
    } state_t;

    // Bits needed to hold the values 0..max_iter inclusive.
    function automatic int iter_width(input int max_iter);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < (max_iter + 1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/diffeq_step_dp.sv
`default_nettype none
// ============================================================================
// Module   : diffeq_step_dp
// Brief    : One Euler step of y'' + 3xy' + 3y = 0, spread over three strobes.
// Revision : 1.0
// ============================================================================
module diffeq_step_dp #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_calc1,
    input  logic                    i_calc2,
    input  logic                    i_calc3,
    input  logic signed [WIDTH-1:0] i_x,
    input  logic signed [WIDTH-1:0] i_dx,
    input  logic signed [WIDTH-1:0] i_u,
    input  logic signed [WIDTH-1:0] i_y,
    output logic signed [WIDTH-1:0] o_x,
    output logic signed [WIDTH-1:0] o_u,
    output logic signed [WIDTH-1:0] o_y
);

    logic signed [WIDTH-1:0] r_xr, r_dxr, r_ur, r_yr;
    logic signed [WIDTH-1:0] r_x3, r_dxu, r_dx3, r_t3, r_t5;

    // All products and sums wrap to WIDTH bits by assignment width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xr  <= '0;
            r_dxr <= '0;
            r_ur  <= '0;
            r_yr  <= '0;
            r_x3  <= '0;
            r_dxu <= '0;
            r_dx3 <= '0;
            r_t3  <= '0;
            r_t5  <= '0;
        end else begin
            if (i_load) begin
                r_xr  <= i_x;
                r_dxr <= i_dx;
                r_ur  <= i_u;
                r_yr  <= i_y;
            end
            if (i_calc1) begin
                r_x3  <= (r_xr << 1) + r_xr;
                r_dxu <= r_dxr * r_ur;
                r_dx3 <= (r_dxr << 1) + r_dxr;
            end
            if (i_calc2) begin
                r_t3 <= r_dxu * r_x3;
                r_t5 <= r_yr * r_dx3;
            end
            if (i_calc3) begin
                r_ur <= r_ur - r_t3 - r_t5;
                r_yr <= r_yr + r_dxu;
                r_xr <= r_xr + r_dxr;
            end
        end
    end

    assign o_x = r_xr;
    assign o_u = r_ur;
    assign o_y = r_yr;

endmodule
`default_nettype wire

// File: rtl/diffeq_solver.sv
`default_nettype none
// ============================================================================
// Module   : diffeq_solver
// Brief    : Iterative Euler solver with ap_* handshake, iteration cap and timeout.
// Revision : 1.0
// ============================================================================
module diffeq_solver
    import diffeq_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int MAX_ITER = 1024,
    localparam int ITER_W   = iter_width(MAX_ITER)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  dx,
    input  logic [WIDTH-1:0]  u,
    input  logic [WIDTH-1:0]  y,
    input  logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  x_out,
    output logic [WIDTH-1:0]  u_out,
    output logic [WIDTH-1:0]  y_out,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              ap_timeout
);

    state_t                  r_state, w_next;
    logic signed [WIDTH-1:0] r_ar;
    logic [ITER_W-1:0]       r_iter;
    logic [WIDTH-1:0]        r_x_out, r_u_out, r_y_out;
    logic [ITER_W-1:0]       r_iter_out;
    logic                    r_timeout;
    logic                    w_load, w_calc1, w_calc2, w_calc3;
    logic signed [WIDTH-1:0] w_xr, w_ur, w_yr;
    logic                    w_bound_hit, w_iter_max, w_finish;

    diffeq_step_dp #(.WIDTH(WIDTH)) u_step_dp (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .i_load  (w_load),
        .i_calc1 (w_calc1),
        .i_calc2 (w_calc2),
        .i_calc3 (w_calc3),
        .i_x     ($signed(x)),
        .i_dx    ($signed(dx)),
        .i_u     ($signed(u)),
        .i_y     ($signed(y)),
        .o_x     (w_xr),
        .o_u     (w_ur),
        .o_y     (w_yr)
    );

    assign w_bound_hit = (w_xr >= r_ar);
    assign w_iter_max  = (r_iter == ITER_W'(MAX_ITER));
    assign w_finish    = (r_state == ST_CHECK) && (w_bound_hit || w_iter_max);

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_calc1 = 1'b0;
        w_calc2 = 1'b0;
        w_calc3 = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_load = 1'b1;
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: w_next = (w_bound_hit || w_iter_max) ? ST_DONE : ST_CALC1;
            ST_CALC1: begin
                w_calc1 = 1'b1;
                w_next  = ST_CALC2;
            end
            ST_CALC2: begin
                w_calc2 = 1'b1;
                w_next  = ST_CALC3;
            end
            ST_CALC3: begin
                w_calc3 = 1'b1;
                w_next  = ST_CHECK;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state    <= ST_IDLE;
            r_ar       <= '0;
            r_iter     <= '0;
            r_x_out    <= '0;
            r_u_out    <= '0;
            r_y_out    <= '0;
            r_iter_out <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_ar   <= $signed(a);
                r_iter <= '0;
            end else if (w_calc3) begin
                r_iter <= r_iter + 1'b1;
            end
            // Bound takes priority: a run that reaches a on the last allowed step is not a timeout.
            if (w_finish) begin
                r_x_out    <= w_xr;
                r_u_out    <= w_ur;
                r_y_out    <= w_yr;
                r_iter_out <= r_iter;
                r_timeout  <= ~w_bound_hit;
            end
        end
    end

    assign ap_done    = (r_state == ST_DONE);
    assign ap_ready   = ap_done;
    assign ap_idle    = (r_state == ST_IDLE) && !ap_start;
    assign x_out      = r_x_out;
    assign u_out      = r_u_out;
    assign y_out      = r_y_out;
    assign iter_cnt   = r_iter_out;
    assign ap_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_diffeq_solver.sv
`default_nettype none
// ============================================================================
// Module   : tb_diffeq_solver
// Brief    : Random and directed checks of diffeq_solver against a loop-level model.
// Revision : 1.0
// ============================================================================
module tb_diffeq_solver;

    localparam int c_MAXI32 = 1024;
    localparam int c_MAXI8  = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        st32, done32, idle32, rdy32, to32;
    logic [31:0] x32, dx32, u32, y32, a32, xo32, uo32, yo32;
    logic [10:0] it32;
    logic        st8, done8, idle8, rdy8, to8;
    logic [7:0]  x8, dx8, u8, y8, a8, xo8, uo8, yo8;
    logic [2:0]  it8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    diffeq_solver #(.WIDTH(32), .MAX_ITER(c_MAXI32)) dut32 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(st32), .ap_done(done32),
        .ap_idle(idle32), .ap_ready(rdy32), .x(x32), .dx(dx32), .u(u32), .y(y32),
        .a(a32), .x_out(xo32), .u_out(uo32), .y_out(yo32), .iter_cnt(it32),
        .ap_timeout(to32)
    );

    diffeq_solver #(.WIDTH(8), .MAX_ITER(c_MAXI8)) dut8 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(st8), .ap_done(done8),
        .ap_idle(idle8), .ap_ready(rdy8), .x(x8), .dx(dx8), .u(u8), .y(y8),
        .a(a8), .x_out(xo8), .u_out(uo8), .y_out(yo8), .iter_cnt(it8),
        .ap_timeout(to8)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        longint m;
        m = v << (64 - w);
        return m >>> (64 - w);
    endfunction

    // Whole Euler loop in plain arithmetic, wrapping every value to w bits.
    task automatic model(input int w, input int maxi,
                         input longint x0, input longint dx0, input longint u0,
                         input longint y0, input longint a0,
                         output longint xf, output longint uf, output longint yf,
                         output int n, output bit to);
        longint xv, uv, yv, dxu, t3, t5;
        xv = x0; uv = u0; yv = y0; n = 0; to = 1'b0;
        while (xv < a0) begin
            if (n == maxi) begin
                to = 1'b1;
                break;
            end
            dxu = wrapw(dx0 * uv, w);
            t3  = wrapw(dxu * wrapw(3 * xv, w), w);
            t5  = wrapw(yv * wrapw(3 * dx0, w), w);
            uv  = wrapw(uv - t3 - t5, w);
            yv  = wrapw(yv + dxu, w);
            xv  = wrapw(xv + dx0, w);
            n++;
        end
        xf = xv; uf = uv; yf = yv;
    endtask

    task automatic read_out(input bit sel, output longint ox, output longint ou,
                            output longint oy, output longint oi, output longint ot);
        if (sel) begin
            ox = wrapw(longint'(xo8), 8); ou = wrapw(longint'(uo8), 8);
            oy = wrapw(longint'(yo8), 8); oi = longint'(it8); ot = longint'(to8);
        end else begin
            ox = wrapw(longint'(xo32), 32); ou = wrapw(longint'(uo32), 32);
            oy = wrapw(longint'(yo32), 32); oi = longint'(it32); ot = longint'(to32);
        end
    endtask

    task automatic run_case(input bit sel, input longint x, input longint dx,
                            input longint u, input longint y, input longint a,
                            input string tag);
        int     w, maxi, lat, n;
        bit     got, to;
        longint ex, eu, ey, ox, ou, oy, oi, ot, hx;
        w    = sel ? 8 : 32;
        maxi = sel ? c_MAXI8 : c_MAXI32;
        @(negedge ap_clk);
        chk({tag, ".idle_before"}, longint'(sel ? idle8 : idle32), 1);
        if (sel) begin
            x8 = x[7:0]; dx8 = dx[7:0]; u8 = u[7:0]; y8 = y[7:0]; a8 = a[7:0]; st8 = 1'b1;
        end else begin
            x32 = x[31:0]; dx32 = dx[31:0]; u32 = u[31:0]; y32 = y[31:0]; a32 = a[31:0]; st32 = 1'b1;
        end
        @(posedge ap_clk);
        #1;
        st8 = 1'b0; st32 = 1'b0;
        lat = 1; got = 1'b0;
        for (int k = 0; k < 4 * maxi + 10 && !got; k++) begin
            @(posedge ap_clk);
            #1;
            lat++;
            got = sel ? done8 : done32;
        end
        if (!got) begin
            chk({tag, ".done_seen"}, 0, 1);
            return;
        end
        model(w, maxi, x, dx, u, y, a, ex, eu, ey, n, to);
        read_out(sel, ox, ou, oy, oi, ot);
        chk({tag, ".latency"}, lat, 2 + 4 * n);
        chk({tag, ".x_out"}, ox, ex);
        chk({tag, ".u_out"}, ou, eu);
        chk({tag, ".y_out"}, oy, ey);
        chk({tag, ".iter_cnt"}, oi, n);
        chk({tag, ".timeout"}, ot, longint'(to));
        chk({tag, ".ready"}, longint'(sel ? rdy8 : rdy32), 1);
        hx = ox;
        @(posedge ap_clk);
        #1;
        read_out(sel, ox, ou, oy, oi, ot);
        chk({tag, ".done_pulse"}, longint'(sel ? done8 : done32), 0);
        chk({tag, ".idle_after"}, longint'(sel ? idle8 : idle32), 1);
        chk({tag, ".x_hold"}, ox, hx);
    endtask

    initial begin
        longint ox, ou, oy, oi, ot, xr, dxr, ar;
        int     seen;
        ap_rst = 1'b1; st32 = 1'b0; st8 = 1'b0;
        x32 = '0; dx32 = '0; u32 = '0; y32 = '0; a32 = '0;
        x8 = '0; dx8 = '0; u8 = '0; y8 = '0; a8 = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            read_out(s[0], ox, ou, oy, oi, ot);
            chk($sformatf("rst%0d.outs", s), ox | ou | oy | oi | ot, 0);
            chk($sformatf("rst%0d.done", s), longint'(s[0] ? done8 : done32), 0);
        end
        ap_rst = 1'b0;

        // Directed cases from the expected-behaviour table.
        run_case(0, 0, 1, 1, 0, 1, "d_a1");
        run_case(0, 0, 1, 1, 0, 2, "d_a2");
        run_case(0, 5, 1, 7, 9, 3, "d_noiter");
        run_case(1, 0, 0, 1, 0, 1, "d_timeout");
        run_case(1, -3, 1, 0, 0, 0, "d_neg");
        run_case(1, 126, 1, 0, 0, 127, "d_edge8");
        run_case(1, 0, 1, 5, 3, 4, "d_exact_cap");

        // Abort in CALC2 of the second iteration.
        @(negedge ap_clk);
        x32 = 0; dx32 = 1; u32 = 1; y32 = 0; a32 = 5; st32 = 1'b1;
        @(posedge ap_clk);
        #1;
        st32 = 1'b0;
        repeat (6) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        read_out(0, ox, ou, oy, oi, ot);
        chk("abort.outs", ox | ou | oy | oi | ot, 0);
        chk("abort.done", longint'(done32), 0);
        chk("abort.idle", longint'(idle32), 1);
        seen = 0;
        repeat (12) begin
            @(posedge ap_clk);
            #1;
            if (done32) seen++;
        end
        chk("abort.no_done", seen, 0);
        run_case(0, 0, 1, 1, 0, 2, "abort.rerun");

        for (int i = 0; i < 40; i++) begin
            xr  = longint'($urandom_range(0, 2000)) - 1000;
            dxr = longint'($urandom_range(1, 20));
            ar  = xr + longint'($urandom_range(0, 200)) - 20;
            run_case(0, xr, dxr, wrapw(longint'($urandom), 32),
                     wrapw(longint'($urandom), 32), ar, $sformatf("r32_%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            xr = longint'($urandom_range(0, 100));
            run_case(0, xr, -longint'(i * 2), wrapw(longint'($urandom), 32),
                     wrapw(longint'($urandom), 32), xr + 10, $sformatf("r32to_%0d", i));
        end
        for (int i = 0; i < 60; i++) begin
            run_case(1, wrapw(longint'($urandom_range(0, 255)), 8),
                     wrapw(longint'($urandom_range(0, 255)), 8),
                     wrapw(longint'($urandom_range(0, 255)), 8),
                     wrapw(longint'($urandom_range(0, 255)), 8),
                     wrapw(longint'($urandom_range(0, 255)), 8), $sformatf("r8_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/diffeq_solver.md
Name: diffeq_solver

Overview:
- Iterative successor to the single-step diffeq datapath: runs the full Euler loop of y'' + 3xy' + 3y = 0 until x reaches bound a, instead of one update.
- Data width and iteration cap are parameters. Adds a timeout flag and an iteration count.
- Same ap_start/ap_done/ap_idle/ap_ready block-level handshake as the existing HLS-style blocks. Sits as a leaf compute block under the control sequencer.

Parameters:
- WIDTH, 32, signed data width of x, dx, u, y, a and all intermediates.
- MAX_ITER, 1024, maximum loop iterations before forced termination (>=1).
- ITER_W, $clog2(MAX_ITER+1), width of iter_cnt (derived, not overridden).

Ports:
- ap_clk  in  1  clock; all state changes on rising edge.
- ap_rst  in  1  synchronous active-high reset.
- ap_start  in  1  start request; sampled only in IDLE.
- ap_done  out  1  high for exactly one cycle in DONE.
- ap_idle  out  1  high in IDLE while ap_start=0.
- ap_ready  out  1  same as ap_done.
- x  in  WIDTH  initial x, signed.
- dx  in  WIDTH  step size, signed.
- u  in  WIDTH  initial u (y'), signed.
- y  in  WIDTH  initial y, signed.
- a  in  WIDTH  loop bound; loop runs while x < a (signed).
- x_out  out  WIDTH  final x.
- u_out  out  WIDTH  final u.
- y_out  out  WIDTH  final y.
- iter_cnt  out  ITER_W  iterations executed.
- ap_timeout  out  1  loop stopped by MAX_ITER with x < a still true.

Behaviour:
- Reset: FSM=IDLE. x_out, u_out, y_out, iter_cnt=0; ap_timeout=0. Internal registers 0. Reset mid-run aborts the run; IDLE on the next cycle, no ap_done.
- FSM is one-hot: IDLE, CHECK, CALC1, CALC2, CALC3, DONE.
- IDLE: on ap_start=1, capture x, dx, u, y, a into xr, dxr, ur, yr, ar; clear iter; go to CHECK. Otherwise stay. ap_start outside IDLE is ignored.
- CHECK:
  - If xr >= ar (signed): go to DONE, timeout=0.
  - Else if iter == MAX_ITER: go to DONE, timeout=1.
  - Else go to CALC1.
- CALC1: x3 <= 3*xr (shift-add); dxu <= dxr*ur; dx3 <= 3*dxr.
- CALC2: t3 <= dxu*x3; t5 <= yr*dx3.
- CALC3, all updates simultaneous, using old values: ur <= ur - t3 - t5; yr <= yr + dxu; xr <= xr + dxr; iter <= iter+1. Then go to CHECK.
- DONE: ap_done=ap_ready=1. Go to IDLE next cycle. Outputs are registered on entry to DONE, valid in the ap_done cycle, and held until the next DONE or reset.
- Arithmetic: two's complement. Every product and sum is truncated to the low WIDTH bits (wrap, no saturation). The compare is signed.
- Latency: start accepted at cycle t (IDLE, ap_start=1) gives ap_done at t + 2 + 4*N, where N = iterations executed. N=0 gives ap_done at t+2.
- Back-to-back: ap_start held high is re-accepted in the IDLE cycle after DONE. Minimum 1 idle cycle between runs.
- dx=0 or dx<0 never terminates by bound; MAX_ITER guarantees termination.

Decomposition:
- Package diffeq_pkg: FSM state encoding constants (one-hot localparams), ITER_W derivation function.
- One sub-module, diffeq_step_dp: the CALC1–CALC3 datapath registers and arithmetic, parametrised by WIDTH, driven by state strobes.
- Top diffeq_solver holds the FSM, the iteration counter, the compare and the output registers.

Test Plan:
- WIDTH=32: x=0, dx=1, u=1, y=0, a=1 -> ap_done at t+6; x_out=1, u_out=1, y_out=1, iter_cnt=1, ap_timeout=0.
- Same inputs with a=2 -> ap_done at t+10; x_out=2, u_out=-5, y_out=2, iter_cnt=2.
- x=5, a=3, u=7, y=9 -> ap_done at t+2; x_out=5, u_out=7, y_out=9, iter_cnt=0.
- MAX_ITER=4: x=0, dx=0, u=1, y=0, a=1 -> ap_done at t+18; iter_cnt=4, ap_timeout=1, u_out=1, y_out=0.
- WIDTH=8: x=-3, dx=1, u=0, y=0, a=0 -> iter_cnt=3, x_out=0 (signed compare); a second run with x=126, dx=1, a=127 -> iter_cnt=1, x_out=127.
- ap_rst asserted in CALC2 of the 2nd iteration -> IDLE next cycle, all outputs 0, no ap_done; a fresh start afterwards gives correct results.
